// File: rtl/serial_frame_pkg.sv
// Shared widths, line constants and state encoding for the single-wire frame serializer.
package serial_frame_pkg;

  localparam int PORT_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = (1 << LEN_W) - 1;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    LEN,
    DATA,
    GAP
  } tx_state_t;

endpackage

// File: rtl/frame_shift_reg.sv
// Parallel-load, left-shift register; the MSB is always the next bit to put on the line.
module frame_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Frame serializer: start bit, port, length and payload fields MSB first, then one idle guard bit.
module serial_frame_tx #(
  parameter int PORT_W = serial_frame_pkg::PORT_W,
  parameter int LEN_W  = serial_frame_pkg::LEN_W,
  parameter int DATA_W = serial_frame_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [PORT_W-1:0] inPort,
  input  logic [LEN_W-1:0]  inLen,
  input  logic [DATA_W-1:0] inData,
  output logic              serOut,
  output logic              serOutValid,
  output logic              transmitted
);

  import serial_frame_pkg::*;

  localparam int CNT_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;

  tx_state_t          state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [LEN_W-1:0]   len_l;
  logic               ser, ser_next;
  logic               ser_valid, ser_valid_next;
  logic               done, done_next;
  logic               accept;
  logic               port_shift, len_shift, data_shift;
  logic               port_bit, len_bit, data_bit;
  logic [DATA_W-1:0]  data_aligned;

  assign accept  = inValid && (state == IDLE);
  assign inReady = (state == IDLE);

  // Left-justify the payload so the first bit to send lands in the MSB.
  assign data_aligned = inData << (DATA_W - int'(inLen));

  frame_shift_reg #(.W(PORT_W)) u_port_sr (
    .clk(clk), .rst(rst), .load(accept), .shift(port_shift), .din(inPort), .msb(port_bit)
  );

  frame_shift_reg #(.W(LEN_W)) u_len_sr (
    .clk(clk), .rst(rst), .load(accept), .shift(len_shift), .din(inLen), .msb(len_bit)
  );

  frame_shift_reg #(.W(DATA_W)) u_data_sr (
    .clk(clk), .rst(rst), .load(accept), .shift(data_shift), .din(data_aligned), .msb(data_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_l     <= '0;
      ser       <= LINE_IDLE;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ser       <= ser_next;
      ser_valid <= ser_valid_next;
      done      <= done_next;
      if (accept) begin
        len_l <= inLen;
      end
    end
  end

  // Outputs are computed for the state being entered, so the registered line
  // value lines up with the state that owns it.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    ser_next       = LINE_IDLE;
    ser_valid_next = 1'b0;
    done_next      = 1'b0;
    port_shift     = 1'b0;
    len_shift      = 1'b0;
    data_shift     = 1'b0;

    case (state)
      IDLE: begin
        if (inValid) begin
          state_next     = START;
          ser_next       = 1'b0;
          ser_valid_next = 1'b1;
        end
      end
      START: begin
        state_next     = PORT;
        ser_next       = port_bit;
        ser_valid_next = 1'b1;
        port_shift     = 1'b1;
        cnt_next       = CNT_W'(PORT_W - 1);
      end
      PORT: begin
        ser_valid_next = 1'b1;
        if (cnt == '0) begin
          state_next = LEN;
          ser_next   = len_bit;
          len_shift  = 1'b1;
          cnt_next   = CNT_W'(LEN_W - 1);
        end else begin
          ser_next   = port_bit;
          port_shift = 1'b1;
          cnt_next   = cnt - CNT_W'(1);
        end
      end
      LEN: begin
        if (cnt == '0) begin
          if (len_l != '0) begin
            state_next     = DATA;
            ser_next       = data_bit;
            ser_valid_next = 1'b1;
            data_shift     = 1'b1;
            cnt_next       = CNT_W'(len_l) - CNT_W'(1);
          end else begin
            state_next = GAP;
            done_next  = 1'b1;
          end
        end else begin
          ser_next       = len_bit;
          ser_valid_next = 1'b1;
          len_shift      = 1'b1;
          cnt_next       = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          state_next = GAP;
          done_next  = 1'b1;
        end else begin
          ser_next       = data_bit;
          ser_valid_next = 1'b1;
          data_shift     = 1'b1;
          cnt_next       = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign serOut      = ser;
  assign serOutValid = ser_valid;
  assign transmitted = done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench: directed frames plus random frames against a bit-stream reference model.
module tb_serial_frame_tx;

  localparam int PW = 2;
  localparam int LW = 4;
  localparam int DW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [PW-1:0] inPort = '0;
  logic [LW-1:0] inLen = '0;
  logic [DW-1:0] inData = '0;
  logic          serOut;
  logic          serOutValid;
  logic          transmitted;

  int checks = 0;
  int failures = 0;

  serial_frame_tx #(.PORT_W(PW), .LEN_W(LW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .inPort(inPort), .inLen(inLen), .inData(inData),
    .serOut(serOut), .serOutValid(serOutValid), .transmitted(transmitted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected line bit in cycle k (k=1 is the start bit) of a frame.
  function automatic logic frame_bit(input logic [PW-1:0] p, input logic [LW-1:0] l,
                                     input logic [DW-1:0] d, input int k);
    int j;
    if (k == 1) return 1'b0;
    j = k - 2;
    if (j < PW) return p[PW-1-j];
    j = j - PW;
    if (j < LW) return l[LW-1-j];
    j = j - LW;
    if (j < int'(l)) return d[int'(l)-1-j];
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag, input int k, input logic s, input logic v,
                               input logic t, input logic r);
    check($sformatf("%s serOut k=%0d", tag, k), serOut, s);
    check($sformatf("%s serOutValid k=%0d", tag, k), serOutValid, v);
    check($sformatf("%s transmitted k=%0d", tag, k), transmitted, t);
    check($sformatf("%s inReady k=%0d", tag, k), inReady, r);
  endtask

  // Called at the negedge of the accept cycle; returns at the negedge of the
  // following IDLE cycle. With keep set, the next frame is presented for that cycle.
  task automatic check_frame(input string tag, input logic [PW-1:0] p, input logic [LW-1:0] l,
                             input logic [DW-1:0] d, input bit keep,
                             input logic [PW-1:0] np, input logic [LW-1:0] nl,
                             input logic [DW-1:0] nd);
    int n;
    n = 1 + PW + LW + int'(l);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k == 1) inValid = keep;
      if (k <= n) check_outputs(tag, k, frame_bit(p, l, d, k), 1'b1, 1'b0, 1'b0);
      else if (k == n + 1) check_outputs(tag, k, 1'b1, 1'b0, 1'b1, 1'b0);
      else check_outputs(tag, k, 1'b1, 1'b0, 1'b0, 1'b1);
      if (k <= n) begin
        inPort = PW'($urandom);
        inLen  = LW'($urandom);
        inData = DW'($urandom);
      end else if (k == n + 1 && keep) begin
        inPort = np;
        inLen  = nl;
        inData = nd;
      end
    end
    $display("frame %s port=%0d len=%0d data=%h done", tag, p, l, d);
  endtask

  task automatic send(input string tag, input logic [PW-1:0] p, input logic [LW-1:0] l,
                      input logic [DW-1:0] d);
    inPort  = p;
    inLen   = l;
    inData  = d;
    inValid = 1'b1;
    check({tag, " accept inReady"}, inReady, 1'b1);
    check_frame(tag, p, l, d, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [PW-1:0] p1, p2;
    logic [LW-1:0] l1, l2;
    logic [DW-1:0] d1, d2;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_outputs("reset_idle", k, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    $display("reset idle window checked");

    send("plan_len3", 2'b10, 4'd3, 15'b101);
    send("plan_len0", 2'b01, 4'd0, 15'h7FFF);
    send("plan_len15", 2'b11, 4'd15, 15'h5555);

    // Back-to-back: inValid stays high, second frame taken in the IDLE cycle after GAP.
    p1 = PW'($urandom); l1 = LW'($urandom_range(1, 15)); d1 = DW'($urandom);
    p2 = PW'($urandom); l2 = LW'($urandom_range(0, 15)); d2 = DW'($urandom);
    inPort = p1; inLen = l1; inData = d1; inValid = 1'b1;
    check("b2b accept inReady", inReady, 1'b1);
    check_frame("b2b_first", p1, l1, d1, 1'b1, p2, l2, d2);
    check_frame("b2b_second", p2, l2, d2, 1'b0, '0, '0, '0);

    // Abort a len=7 frame with reset in cycle 5.
    p1 = PW'($urandom); d1 = DW'($urandom);
    inPort = p1; inLen = 4'd7; inData = d1; inValid = 1'b1;
    check("abort accept inReady", inReady, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) inValid = 1'b0;
      check_outputs("abort", k, frame_bit(p1, 4'd7, d1, k), 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs("abort_reset", 6, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 7; k < 20; k++) begin
      @(negedge clk);
      check_outputs("abort_after", k, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    $display("abort by reset checked");

    send("post_abort", 2'b10, 4'd7, 15'h1234);

    for (int i = 0; i < 8; i++) begin
      send($sformatf("rand%0d", i), PW'($urandom), LW'($urandom), DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
